// File: rtl/comparador_serial_if.sv
// Operand/command and result bundle for the bit-serial magnitude comparator.
interface comparador_serial_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] wordA;
  logic [WIDTH-1:0] wordB;
  logic             dir;
  logic             signed_mode;
  logic             busy;
  logic             done;
  logic             lt;
  logic             eq;
  logic             gt;
  logic             z;

  modport master (
    output start, wordA, wordB, dir, signed_mode,
    input  busy, done, lt, eq, gt, z
  );

  modport slave (
    input  start, wordA, wordB, dir, signed_mode,
    output busy, done, lt, eq, gt, z
  );
endinterface

// File: rtl/comparador_serial.sv
// Bit-serial comparator: one bit pair per clock, either scan order, optional
// early exit on the first MSB-side difference, unsigned or two's complement.
//
// state | meaning
// IDLE  | waiting for start, results held
// SCAN  | processing one bit pair per edge, busy=1
// DONE  | one-cycle done pulse, results just updated; start restarts
module comparador_serial #(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  comparador_serial_if.slave bus
);
  localparam int              IW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0]   IDX_MSB = IW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             dir_q, dir_d, sgn_q, sgn_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             lt_t_q, lt_t_d, gt_t_q, gt_t_d;
  logic             lt_q, lt_d, eq_q, eq_d, gt_q, gt_d;
  logic             a_bit, b_bit, a_wins, last_bit, early;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      dir_q   <= 1'b0;
      sgn_q   <= 1'b0;
      idx_q   <= '0;
      lt_t_q  <= 1'b0;
      gt_t_q  <= 1'b0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      dir_q   <= dir_d;
      sgn_q   <= sgn_d;
      idx_q   <= idx_d;
      lt_t_q  <= lt_t_d;
      gt_t_q  <= gt_t_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    dir_d    = dir_q;
    sgn_d    = sgn_q;
    idx_d    = idx_q;
    lt_t_d   = lt_t_q;
    gt_t_d   = gt_t_q;
    lt_d     = lt_q;
    eq_d     = eq_q;
    gt_d     = gt_q;
    early    = 1'b0;
    a_bit    = a_q[idx_q];
    b_bit    = b_q[idx_q];
    // The sign bit carries negative weight, so a 1 there means "smaller".
    a_wins   = a_bit ^ (sgn_q && (idx_q == IDX_MSB));
    last_bit = dir_q ? (idx_q == '0) : (idx_q == IDX_MSB);

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          a_d     = bus.wordA;
          b_d     = bus.wordB;
          dir_d   = bus.dir;
          sgn_d   = bus.signed_mode;
          lt_t_d  = 1'b0;
          gt_t_d  = 1'b0;
          idx_d   = bus.dir ? IDX_MSB : '0;
          state_d = SCAN;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        if (a_bit != b_bit) begin
          // MSB-first keeps only the first difference; LSB-first lets later
          // (more significant) differences overwrite earlier ones.
          if (!dir_q || !(lt_t_q || gt_t_q)) begin
            lt_t_d = ~a_wins;
            gt_t_d = a_wins;
          end
          early = dir_q && EARLY_EXIT;
        end
        if (last_bit || early) begin
          state_d = DONE;
          lt_d    = lt_t_d;
          gt_d    = gt_t_d;
          eq_d    = ~(lt_t_d | gt_t_d);
        end else begin
          idx_d = dir_q ? (idx_q - IW'(1)) : (idx_q + IW'(1));
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy = (state_q == SCAN);
  assign bus.done = (state_q == DONE);
  assign bus.lt   = lt_q;
  assign bus.eq   = eq_q;
  assign bus.gt   = gt_q;
  assign bus.z    = lt_q | eq_q;
endmodule

// File: doc/comparador_serial.md
COMPARADOR_SERIAL -- requirements
Module: comparador_serial

Interface
REQ-001 Parameter WIDTH, default 8: operand width in bits; legal range 2..64.
REQ-002 Parameter EARLY_EXIT, default 1: when 1, MSB-first scans stop at the first differing bit.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  request; sampled only when busy=0.
REQ-006 wordA  input  WIDTH  operand A; captured on the accepted start edge.
REQ-007 wordB  input  WIDTH  operand B; captured on the accepted start edge.
REQ-008 dir  input  1  scan order, captured with operands: 0 = right-to-left (LSB first), 1 = left-to-right (MSB first).
REQ-009 signed_mode  input  1  captured with operands: 0 = unsigned, 1 = two's complement.
REQ-010 busy  output  1  high while a scan is in progress.
REQ-011 done  output  1  one-cycle pulse marking valid results.
REQ-012 lt, eq, gt  output  1 each  A<B, A==B, A>B; one-hot once valid.
REQ-013 z  output  1  A<=B (lt | eq).

Function
REQ-014 The FSM SHALL have three states: IDLE, SCAN, DONE.
REQ-015 start=1 in IDLE or DONE SHALL, at that edge (E0):
- capture wordA, wordB, dir and signed_mode;
- clear the internal lt/gt trackers;
- load the bit index with 0 (dir=0) or WIDTH-1 (dir=1);
- enter SCAN with busy=1.
REQ-016 In SCAN, each edge SHALL process exactly one bit pair and step the index by +1 (dir=0) or -1 (dir=1).
REQ-017 For a differing pair, A_bit=1 SHALL set gt and clear lt, and A_bit=0 SHALL set lt and clear gt; the sense is inverted at bit WIDTH-1 when signed_mode=1.
REQ-018 dir=0 SHALL overwrite the trackers on every differing bit, so the most-significant difference decides the result.
REQ-019 dir=1 with EARLY_EXIT=1 SHALL enter DONE on the edge that processes the first differing bit.
REQ-020 dir=1 with EARLY_EXIT=0 SHALL record only the first difference, ignore later differences, and scan all bits.
REQ-021 After processing bit WIDTH-1 (dir=0) or bit 0 (dir=1), SCAN SHALL enter DONE.
REQ-022 Latency SHALL be WIDTH edges after E0 for full scans and k edges for an early exit at the k-th processed bit (1<=k<=WIDTH).
REQ-023 Results SHALL be valid in the DONE cycle:
- eq=1 when neither tracker is set;
- done=1 and busy=0.
REQ-024 DONE SHALL return to IDLE after one cycle unless start=1, which restarts per REQ-015; done stays high only in the DONE cycle.
REQ-025 lt/eq/gt/z SHALL hold their last values from DONE until the next DONE; they are not cleared by start or during SCAN.
REQ-026 start while busy=1 SHALL be ignored; the operand inputs may change freely during SCAN without effect.
REQ-027 The index SHALL never leave 0..WIDTH-1, with no wrap-around.

Reset
REQ-028 rst_n=0 SHALL, asynchronously:
- force IDLE and clear the index, operand registers and trackers;
- set busy=0, done=0, lt=0, eq=0, gt=0, z=0.
REQ-029 Reset asserted mid-SCAN SHALL abort the scan with no done pulse.
REQ-030 After rst_n rises, the first start SHALL be accepted on the next rising edge.

Verification (WIDTH=8, EARLY_EXIT=1 unless stated)
REQ-031 A=00, B=00, dir=0 -> done 8 cycles after E0, eq=1, z=1, lt=gt=0.
REQ-032 A=06, B=01, dir=0 -> gt=1, z=0 at cycle 8; A=E7, B=81, dir=0 -> gt=1, z=0; A=00, B=01 -> lt=1, z=1.
REQ-033 A=80, B=7F, dir=1, unsigned -> done 1 cycle after E0, gt=1; same operands with signed_mode=1 -> lt=1, z=1.
REQ-034 A=0B, B=08, dir=1, EARLY_EXIT=1 -> done 7 cycles after E0, gt=1; with EARLY_EXIT=0 -> done at cycle 8, gt=1.
REQ-035 Pulse start at cycle 3 of a scan, then start again in the DONE cycle -> first pulse ignored; second scan runs with the new operands and no idle cycle between them.
REQ-036 rst_n=0 at cycle 4 of a dir=0 scan -> all outputs 0 immediately with no done pulse; a new start after release completes normally.
